// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS pipeline: ALUOp/funct/ALUCon encodings,
// the ID/EX register layout and the operand forwarding mux.
package mips_pkg;

  localparam int unsigned DataW = 32;
  localparam int unsigned RegW  = 5;

  localparam logic [1:0] ALUOP_MEM  = 2'b00;
  localparam logic [1:0] ALUOP_BR   = 2'b01;
  localparam logic [1:0] ALUOP_R    = 2'b10;
  localparam logic [1:0] ALUOP_SLTI = 2'b11;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_BAD = 4'b1111;

  typedef struct packed {
    logic             valid;
    logic [1:0]       alu_op;
    logic [5:0]       funct;
    logic [DataW-1:0] rs_data;
    logic [DataW-1:0] rt_data;
    logic [DataW-1:0] imm;
    logic [RegW-1:0]  rs;
    logic [RegW-1:0]  rt;
    logic [RegW-1:0]  rd;
    logic             alu_src;
    logic             reg_dst;
    logic             reg_write;
    logic             mem_read;
    logic             mem_write;
    logic             mem_to_reg;
  } ex_reg_t;

  // EX/MEM has priority over MEM/WB; register $0 is never forwarded.
  function automatic logic [DataW-1:0] fwd_sel(
    input logic [RegW-1:0]  idx,
    input logic [DataW-1:0] reg_data,
    input logic             exmem_we,
    input logic [RegW-1:0]  exmem_rd,
    input logic [DataW-1:0] exmem_res,
    input logic             memwb_we,
    input logic [RegW-1:0]  memwb_rd,
    input logic [DataW-1:0] memwb_res
  );
    logic [DataW-1:0] res;
    res = reg_data;
    if (exmem_we && (exmem_rd != '0) && (exmem_rd == idx)) begin
      res = exmem_res;
    end else if (memwb_we && (memwb_rd != '0) && (memwb_rd == idx)) begin
      res = memwb_res;
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_control.sv
// ALUOp/funct to 4-bit ALU control decoder; purely combinational so the
// multicycle datapath can share it.
module alu_control
  import mips_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_con_o
);

  always_comb begin
    alu_con_o = ALU_BAD;
    unique case (alu_op_i)
      ALUOP_MEM:  alu_con_o = ALU_ADD;
      ALUOP_BR:   alu_con_o = ALU_SUB;
      ALUOP_SLTI: alu_con_o = ALU_SLT;
      ALUOP_R: begin
        case (funct_i)
          FUNCT_ADD: alu_con_o = ALU_ADD;
          FUNCT_SUB: alu_con_o = ALU_SUB;
          FUNCT_AND: alu_con_o = ALU_AND;
          FUNCT_OR:  alu_con_o = ALU_OR;
          FUNCT_SLT: alu_con_o = ALU_SLT;
          default:   alu_con_o = ALU_BAD;
        endcase
      end
      default: alu_con_o = ALU_BAD;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, flush/hold handling,
// ALU control generation and EX-stage operand forwarding.
module id_ex_stage
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [1:0]       id_ALUOp,
  input  logic [5:0]       id_funct,
  input  logic [DataW-1:0] id_rs_data,
  input  logic [DataW-1:0] id_rt_data,
  input  logic [DataW-1:0] id_imm,
  input  logic [RegW-1:0]  id_rs,
  input  logic [RegW-1:0]  id_rt,
  input  logic [RegW-1:0]  id_rd,
  input  logic             id_ALUSrc,
  input  logic             id_RegDst,
  input  logic             id_RegWrite,
  input  logic             id_MemRead,
  input  logic             id_MemWrite,
  input  logic             id_MemtoReg,
  input  logic             flush,
  input  logic             hold,
  input  logic             exmem_RegWrite,
  input  logic [RegW-1:0]  exmem_rd,
  input  logic [DataW-1:0] exmem_result,
  input  logic             memwb_RegWrite,
  input  logic [RegW-1:0]  memwb_rd,
  input  logic [DataW-1:0] memwb_result,
  output logic [3:0]       ALUCon,
  output logic [DataW-1:0] a,
  output logic [DataW-1:0] b,
  output logic [DataW-1:0] store_data,
  output logic             ex_valid,
  output logic             ex_RegWrite,
  output logic             ex_MemRead,
  output logic             ex_MemWrite,
  output logic             ex_MemtoReg,
  output logic [RegW-1:0]  ex_wreg,
  output logic             stall_id
);

  ex_reg_t ex_q, ex_d, id_pkt;
  logic    load_use;
  logic    [DataW-1:0] fwd_rs, fwd_rt;

  always_comb begin
    id_pkt            = '0;
    id_pkt.valid      = id_valid;
    id_pkt.alu_op     = id_ALUOp;
    id_pkt.funct      = id_funct;
    id_pkt.rs_data    = id_rs_data;
    id_pkt.rt_data    = id_rt_data;
    id_pkt.imm        = id_imm;
    id_pkt.rs         = id_rs;
    id_pkt.rt         = id_rt;
    id_pkt.rd         = id_rd;
    id_pkt.alu_src    = id_ALUSrc;
    id_pkt.reg_dst    = id_RegDst;
    id_pkt.reg_write  = id_RegWrite;
    id_pkt.mem_read   = id_MemRead;
    id_pkt.mem_write  = id_MemWrite;
    id_pkt.mem_to_reg = id_MemtoReg;
  end

  assign load_use = id_valid & ex_q.valid & ex_q.mem_read & (ex_q.rt != '0) &
                    ((ex_q.rt == id_rs) | (ex_q.rt == id_rt));
  assign stall_id = load_use | hold;

  // Priority below reset: flush > hold > load-use bubble > load.
  always_comb begin
    ex_d = id_pkt;
    if (flush) begin
      ex_d = '0;
    end else if (hold) begin
      ex_d = ex_q;
    end else if (load_use) begin
      ex_d.valid      = 1'b0;
      ex_d.alu_src    = 1'b0;
      ex_d.reg_dst    = 1'b0;
      ex_d.reg_write  = 1'b0;
      ex_d.mem_read   = 1'b0;
      ex_d.mem_write  = 1'b0;
      ex_d.mem_to_reg = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

  alu_control u_alu_control (
    .alu_op_i  (ex_q.alu_op),
    .funct_i   (ex_q.funct),
    .alu_con_o (ALUCon)
  );

  always_comb begin
    fwd_rs = fwd_sel(ex_q.rs, ex_q.rs_data, exmem_RegWrite, exmem_rd, exmem_result,
                     memwb_RegWrite, memwb_rd, memwb_result);
    fwd_rt = fwd_sel(ex_q.rt, ex_q.rt_data, exmem_RegWrite, exmem_rd, exmem_result,
                     memwb_RegWrite, memwb_rd, memwb_result);
  end

  assign a          = fwd_rs;
  assign b          = ex_q.alu_src ? ex_q.imm : fwd_rt;
  assign store_data = fwd_rt;

  assign ex_valid    = ex_q.valid;
  assign ex_RegWrite = ex_q.reg_write  & ex_q.valid;
  assign ex_MemRead  = ex_q.mem_read   & ex_q.valid;
  assign ex_MemWrite = ex_q.mem_write  & ex_q.valid;
  assign ex_MemtoReg = ex_q.mem_to_reg & ex_q.valid;
  assign ex_wreg     = ex_q.reg_dst ? ex_q.rd : ex_q.rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed-vector bench for id_ex_stage with hand-computed expectations.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [1:0]  id_ALUOp;
  logic [5:0]  id_funct;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_ALUSrc, id_RegDst, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg;
  logic        flush, hold;
  logic        exmem_RegWrite, memwb_RegWrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [3:0]  ALUCon;
  logic [31:0] a, b, store_data;
  logic        ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg;
  logic [4:0]  ex_wreg;
  logic        stall_id;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk            (clk),
    .reset          (reset),
    .id_valid       (id_valid),
    .id_ALUOp       (id_ALUOp),
    .id_funct       (id_funct),
    .id_rs_data     (id_rs_data),
    .id_rt_data     (id_rt_data),
    .id_imm         (id_imm),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .id_ALUSrc      (id_ALUSrc),
    .id_RegDst      (id_RegDst),
    .id_RegWrite    (id_RegWrite),
    .id_MemRead     (id_MemRead),
    .id_MemWrite    (id_MemWrite),
    .id_MemtoReg    (id_MemtoReg),
    .flush          (flush),
    .hold           (hold),
    .exmem_RegWrite (exmem_RegWrite),
    .exmem_rd       (exmem_rd),
    .exmem_result   (exmem_result),
    .memwb_RegWrite (memwb_RegWrite),
    .memwb_rd       (memwb_rd),
    .memwb_result   (memwb_result),
    .ALUCon         (ALUCon),
    .a              (a),
    .b              (b),
    .store_data     (store_data),
    .ex_valid       (ex_valid),
    .ex_RegWrite    (ex_RegWrite),
    .ex_MemRead     (ex_MemRead),
    .ex_MemWrite    (ex_MemWrite),
    .ex_MemtoReg    (ex_MemtoReg),
    .ex_wreg        (ex_wreg),
    .stall_id       (stall_id)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Step one clock and let outputs settle before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ctrl = {ALUSrc, RegDst, RegWrite, MemRead, MemWrite, MemtoReg}
  task automatic drive(input logic v, input logic [1:0] op, input logic [5:0] fn,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] im,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [5:0] ctrl);
    id_valid   = v;
    id_ALUOp   = op;
    id_funct   = fn;
    id_rs_data = rsd;
    id_rt_data = rtd;
    id_imm     = im;
    id_rs      = rs;
    id_rt      = rt;
    id_rd      = rd;
    {id_ALUSrc, id_RegDst, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg} = ctrl;
  endtask

  task automatic fwd_set(input logic ew, input logic [4:0] erd, input logic [31:0] eres,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] mres);
    exmem_RegWrite = ew;
    exmem_rd       = erd;
    exmem_result   = eres;
    memwb_RegWrite = mw;
    memwb_rd       = mrd;
    memwb_result   = mres;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0;
    hold  = 1'b0;
    drive(1'b0, 2'b00, 6'h00, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 6'b000000);
    fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    tick();
    tick();
    check_eq("rst_alucon", ALUCon, 32'h2);
    check_eq("rst_a", a, 32'h0);
    check_eq("rst_b", b, 32'h0);
    check_eq("rst_store", store_data, 32'h0);
    check_eq("rst_valid", ex_valid, 32'h0);
    check_eq("rst_stall", stall_id, 32'h0);
    reset = 1'b0;

    // R-type add
    drive(1'b1, 2'b10, 6'b100000, 32'd5, 32'd7, 32'h0, 5'd1, 5'd2, 5'd3, 6'b011000);
    tick();
    check_eq("add_alucon", ALUCon, 32'h2);
    check_eq("add_a", a, 32'd5);
    check_eq("add_b", b, 32'd7);
    check_eq("add_regwrite", ex_RegWrite, 32'h1);
    check_eq("add_wreg", ex_wreg, 32'd3);

    // Forwarding: sub with rs=3, rt=5
    drive(1'b1, 2'b10, 6'b100010, 32'h99, 32'h55, 32'h0, 5'd3, 5'd5, 5'd6, 6'b011000);
    tick();
    check_eq("sub_alucon", ALUCon, 32'h6);
    fwd_set(1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    check_eq("fwd_exmem_wins", a, 32'h11);
    fwd_set(1'b0, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22);
    check_eq("fwd_memwb", a, 32'h22);
    fwd_set(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22);
    check_eq("fwd_rd0", a, 32'h99);
    fwd_set(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h77);
    check_eq("fwd_rt_b", b, 32'h77);
    check_eq("fwd_rt_store", store_data, 32'h77);
    check_eq("fwd_rs_untouched", a, 32'h99);
    fwd_set(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

    // lw $4, 8($1)
    drive(1'b1, 2'b00, 6'h00, 32'd100, 32'h0, 32'd8, 5'd1, 5'd4, 5'd0, 6'b101101);
    tick();
    check_eq("lw_memread", ex_MemRead, 32'h1);
    check_eq("lw_a", a, 32'd100);
    check_eq("lw_b", b, 32'd8);
    check_eq("lw_wreg", ex_wreg, 32'd4);
    // Dependent add uses $4 as rs
    drive(1'b1, 2'b10, 6'b100000, 32'h0, 32'h0, 32'h0, 5'd4, 5'd6, 5'd7, 6'b011000);
    #1;
    check_eq("lu_stall", stall_id, 32'h1);
    tick();
    check_eq("lu_bubble_valid", ex_valid, 32'h0);
    check_eq("lu_bubble_memread", ex_MemRead, 32'h0);
    check_eq("lu_bubble_regwrite", ex_RegWrite, 32'h0);
    check_eq("lu_stall_cleared", stall_id, 32'h0);
    tick();
    check_eq("lu_enter_valid", ex_valid, 32'h1);
    check_eq("lu_enter_regwrite", ex_RegWrite, 32'h1);
    check_eq("lu_enter_wreg", ex_wreg, 32'd7);

    // flush + load-use: lw in EX, sw using $4 in decode
    drive(1'b1, 2'b00, 6'h00, 32'd100, 32'h0, 32'd8, 5'd1, 5'd4, 5'd0, 6'b101101);
    tick();
    drive(1'b1, 2'b00, 6'h00, 32'h0, 32'hAB, 32'd4, 5'd4, 5'd2, 5'd0, 6'b100010);
    flush = 1'b1;
    #1;
    check_eq("fl_lu_stall", stall_id, 32'h1);
    tick();
    flush = 1'b0;
    #1;
    check_eq("fl_valid", ex_valid, 32'h0);
    check_eq("fl_memwrite", ex_MemWrite, 32'h0);
    check_eq("fl_no_double_stall", stall_id, 32'h0);
    tick();
    check_eq("sw_valid", ex_valid, 32'h1);
    check_eq("sw_memwrite", ex_MemWrite, 32'h1);
    check_eq("sw_store", store_data, 32'hAB);

    // hold for 3 cycles while decode presents an or
    hold = 1'b1;
    drive(1'b1, 2'b10, 6'b100101, 32'h0F, 32'hF0, 32'h0, 5'd8, 5'd9, 5'd10, 6'b011000);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_stall", stall_id, 32'h1);
      check_eq("hold_memwrite", ex_MemWrite, 32'h1);
      check_eq("hold_regwrite", ex_RegWrite, 32'h0);
      check_eq("hold_alucon", ALUCon, 32'h2);
    end
    hold = 1'b0;
    tick();
    check_eq("rel_alucon", ALUCon, 32'h1);
    check_eq("rel_regwrite", ex_RegWrite, 32'h1);
    check_eq("rel_a", a, 32'h0F);
    check_eq("rel_stall", stall_id, 32'h0);

    // hold + flush: flush wins
    hold  = 1'b1;
    flush = 1'b1;
    tick();
    hold  = 1'b0;
    flush = 1'b0;
    #1;
    check_eq("hold_flush_valid", ex_valid, 32'h0);

    // ALUCon decode corners
    drive(1'b1, 2'b10, 6'b000000, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 6'b011000);
    tick();
    check_eq("bad_funct", ALUCon, 32'hF);
    drive(1'b1, 2'b10, 6'b100100, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 6'b011000);
    tick();
    check_eq("and_alucon", ALUCon, 32'h0);
    drive(1'b1, 2'b10, 6'b101010, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 6'b011000);
    tick();
    check_eq("slt_alucon", ALUCon, 32'h7);
    drive(1'b1, 2'b01, 6'h00, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd0, 6'b000000);
    tick();
    check_eq("beq_alucon", ALUCon, 32'h6);
    drive(1'b1, 2'b11, 6'h00, 32'h3, 32'h0, 32'hFFFFFFFF, 5'd1, 5'd2, 5'd0, 6'b101000);
    tick();
    check_eq("slti_alucon", ALUCon, 32'h7);
    check_eq("slti_b", b, 32'hFFFFFFFF);
    check_eq("slti_a", a, 32'h3);

    // reset beats hold
    reset = 1'b1;
    hold  = 1'b1;
    tick();
    reset = 1'b0;
    hold  = 1'b0;
    #1;
    check_eq("midrst_valid", ex_valid, 32'h0);
    check_eq("midrst_alucon", ALUCon, 32'h2);
    check_eq("midrst_a", a, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 5-stage MIPS core, directly upstream of the ALU. Captures decoded instruction fields on each clock, generates the 4-bit ALU control code from ALUOp/funct, and drives forwarded operands a/b into the ALU during EX. It also detects load-use hazards, stalls decode, and accepts flush/hold from the rest of the pipeline.

## Interface
- No parameters. Data width is fixed at 32 bits and register index width at 5 bits.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_valid  in  1  decode holds a real instruction
- id_ALUOp  in  2  00 = mem, 01 = branch, 10 = R-type, 11 = slti
- id_funct  in  6  instruction[5:0]
- id_rs_data, id_rt_data, id_imm  in  32  register reads and sign-extended immediate
- id_rs, id_rt, id_rd  in  5  register indices
- id_ALUSrc, id_RegDst, id_RegWrite, id_MemRead, id_MemWrite, id_MemtoReg  in  1  control bits
- flush  in  1  branch taken; kill the instruction entering EX
- hold  in  1  downstream busy; freeze the EX register
- exmem_RegWrite  in  1, exmem_rd  in  5, exmem_result  in  32  EX/MEM forwarding source
- memwb_RegWrite  in  1, memwb_rd  in  5, memwb_result  in  32  MEM/WB forwarding source
- ALUCon  out  4  to ALU
- a, b  out  32  to ALU
- store_data  out  32  forwarded rt, used for sw
- ex_valid, ex_RegWrite, ex_MemRead, ex_MemWrite, ex_MemtoReg  out  1
- ex_wreg  out  5  destination register (rd if RegDst, else rt)
- stall_id  out  1  decode and PC must hold

## Operation
- The EX register holds valid, ALUOp, funct, rs_data, rt_data, imm, rs, rt, rd, and the six control bits.
- Update priority on each posedge: reset > flush > hold > load-use bubble > load.
  - reset or flush: all fields cleared to 0 (bubble).
  - hold: register keeps its contents.
  - bubble: valid and all control bits 0.
  - load: capture the id_* inputs.
- Load-use condition: stall_id = id_valid & ex_valid & ex_MemRead & (ex_rt != 0) & (ex_rt == id_rs | ex_rt == id_rt), OR hold. It is combinational.
- The load-use bubble is inserted only when hold = 0 and flush = 0.
- ALUCon decode (combinational from registered ALUOp/funct):
  - ALUOp 00 → 0010
  - ALUOp 01 → 0110
  - ALUOp 11 → 0111
  - ALUOp 10, funct 100000 → 0010 (add)
  - ALUOp 10, funct 100010 → 0110 (sub)
  - ALUOp 10, funct 100100 → 0000 (and)
  - ALUOp 10, funct 100101 → 0001 (or)
  - ALUOp 10, funct 101010 → 0111 (slt)
  - ALUOp 10, any other funct → 1111
- Forwarding, applied per operand (rs, rt):
  - If exmem_RegWrite, exmem_rd != 0 and exmem_rd == index → exmem_result.
  - Else if memwb_RegWrite, memwb_rd != 0 and memwb_rd == index → memwb_result.
  - Else use the registered data.
  - EX/MEM wins when both match.
- a = forwarded rs.
- b = ex_ALUSrc ? imm : forwarded rt.
- store_data = forwarded rt (always, independent of ALUSrc).
- ex_* control outputs are ANDed with ex_valid.

## Timing
- Latency: one cycle from the id_* inputs to the registered EX fields.
- ALUCon, a, b, store_data, and stall_id are combinational from registered state and the current forwarding inputs.
- Reset values:
  - all registered fields 0
  - ALUCon = 0010 (ALUOp 00)
  - a = 0, b = 0, store_data = 0
  - all ex_* outputs 0; ex_wreg = 0
  - stall_id = 0
- Reset asserted mid-pipeline clears the stage on the next edge regardless of flush/hold.
- flush and load-use in the same cycle: flush wins; the bubble is still inserted.
- hold and flush in the same cycle: flush wins.
- A forwarding index of 0 never forwards; register $0 always reads as the registered data.

## Structure
- Package mips_pkg holds:
  - ALUOp constants (ALUOP_MEM, ALUOP_BR, ALUOP_R, ALUOP_SLTI)
  - funct constants
  - ALUCon constants (ALU_AND = 0000, ALU_OR = 0001, ALU_ADD = 0010, ALU_SUB = 0110, ALU_SLT = 0111, ALU_BAD = 1111)
- One sub-module, alu_control: combinational ALUOp/funct → ALUCon decoder, reused by the multicycle variant.

## Test plan
- Reset, then load R-type add (funct 100000) with rs_data = 5, rt_data = 7 → next cycle ALUCon = 0010, a = 5, b = 7, ex_RegWrite = 1.
- EX/MEM and MEM/WB both write rd = 3 with 0x11 and 0x22, EX holds rs = 3 → a = 0x11. Repeat with rd = 0 → a = registered rs_data.
- lw in EX with ex_rt = 4, decode presents rs = 4 → stall_id = 1; the next edge inserts a bubble (ex_valid = 0, ex_MemRead = 0) and decode's instruction enters one cycle later.
- flush asserted with a valid sw in decode → ex_valid = 0 and ex_MemWrite = 0 next cycle. flush + load-use in the same cycle → bubble, no double stall.
- hold = 1 for 3 cycles → EX fields unchanged and stall_id = 1. Release → normal loading resumes.
- ALUOp 10, funct 000000 → ALUCon = 1111. ALUOp 11 with imm = 0xFFFFFFFF and ALUSrc = 1 → ALUCon = 0111, b = 0xFFFFFFFF.
